// File: rtl/core_pkg.sv
// core_pkg: constants and types shared by the banked register file.
// Bank encodings, default register width, the SP/GP initial values and
// their register numbers, the debug tap register, and the init FSM states.
package core_pkg;

    localparam int          CORE_XLEN    = 32;

    // Bank encodings: bank 0 carries the hard-wired zero register.
    localparam int          BANK_INT     = 0;
    localparam int          BANK_FP      = 1;

    localparam int          CORE_SP_IDX  = 2;
    localparam int unsigned CORE_SP_INIT = 32'd524284;
    localparam int          CORE_GP_IDX  = 3;
    localparam int unsigned CORE_GP_INIT = 32'd262140;

    // Integer register exposed on dbg_a0 (a0 in the integer ABI).
    localparam int          DBG_IDX      = 10;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } rf_state_e;

    // Bank-select width; a single bank still gets a 1-bit select.
    function automatic int bank_bits(input int nbanks);
        return (nbanks > 1) ? $clog2(nbanks) : 1;
    endfunction

endpackage

// File: rtl/regfile_banked_if.sv
// regfile_banked_if: read/write bus of the banked register file.
//   rd_addr/rd_bank  read register numbers and bank selects, port i at [i*W +: W]
//   rd_data          read data, port i at [i*XLEN +: XLEN]
//   wr_en/addr/bank/data  write ports, same packing
//   init_done        high once the post-reset clear has finished
//   dbg_a0           stored value of integer register 10
// master = decode/writeback side, slave = register file.
interface regfile_banked_if import core_pkg::*; #(
    parameter int XLEN = CORE_XLEN,
    parameter int AW   = 5,
    parameter int BW   = 1,
    parameter int NRD  = 3,
    parameter int NWR  = 2
);
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*BW-1:0]   rd_bank;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*BW-1:0]   wr_bank;
    logic [NWR*XLEN-1:0] wr_data;
    logic                init_done;
    logic [XLEN-1:0]     dbg_a0;

    modport master (
        output rd_addr, rd_bank, wr_en, wr_addr, wr_bank, wr_data,
        input  rd_data, init_done, dbg_a0
    );

    modport slave (
        input  rd_addr, rd_bank, wr_en, wr_addr, wr_bank, wr_data,
        output rd_data, init_done, dbg_a0
    );
endinterface

// File: rtl/regfile_bank.sv
// regfile_bank: one NREG x XLEN register bank.
//   clk    rising-edge write clock
//   we/waddr/wdata  NWR write ports; the highest-numbered enabled port wins
//                   on an address collision
//   raddr/rdata     NRD combinational read ports
// ZERO_R0=1 makes entry 0 read as zero and discard writes.
// Contents are deliberately not reset; the top's init engine clears them.
module regfile_bank import core_pkg::*; #(
    parameter int XLEN    = CORE_XLEN,
    parameter int NREG    = 32,
    parameter int NRD     = 3,
    parameter int NWR     = 2,
    parameter bit ZERO_R0 = 1'b0,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                      clk,
    input  logic [NWR-1:0]            we,
    input  logic [NWR-1:0][AW-1:0]    waddr,
    input  logic [NWR-1:0][XLEN-1:0]  wdata,
    input  logic [NRD-1:0][AW-1:0]    raddr,
    output logic [NRD-1:0][XLEN-1:0]  rdata
);

    logic [XLEN-1:0] mem [NREG];

    // Later loop iterations override earlier ones, so port NWR-1 has priority.
    always_ff @(posedge clk) begin
        for (int w = 0; w < NWR; w++) begin
            if (we[w] && !(ZERO_R0 && (waddr[w] == '0))) begin
                mem[waddr[w]] <= wdata[w];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NRD; r++) begin
            rdata[r] = (ZERO_R0 && (raddr[r] == '0)) ? '0 : mem[raddr[r]];
        end
    end

endmodule

// File: rtl/regfile_banked.sv
// regfile_banked: NBANKS x NREG x XLEN register file (bank 0 integer with
// hard-wired x0, other banks float-style).
//   clk        rising-edge clock
//   rst        asynchronous active-low reset; restarts the clear sequence
//   bus        regfile_banked_if slave: NRD combinational reads, NWR
//              prioritised writes, init_done, dbg_a0
// After reset an init engine walks clr_idx over every entry of every bank,
// writing zero (SP/GP get their initial values). Writes are dropped and all
// read outputs are zero until init_done. With BYPASS=1 a write being
// performed this cycle is forwarded to matching read ports.
module regfile_banked import core_pkg::*; #(
    parameter int          XLEN    = CORE_XLEN,
    parameter int          NREG    = 32,
    parameter int          NBANKS  = 2,
    parameter int          NRD     = 3,
    parameter int          NWR     = 2,
    parameter int          BYPASS  = 1,
    parameter int          SP_IDX  = CORE_SP_IDX,
    parameter int unsigned SP_INIT = CORE_SP_INIT,
    parameter int          GP_IDX  = CORE_GP_IDX,
    parameter int unsigned GP_INIT = CORE_GP_INIT
) (
    input  logic           clk,
    input  logic           rst,
    regfile_banked_if.slave bus
);

    localparam int             AW       = $clog2(NREG);
    localparam int             BW       = bank_bits(NBANKS);
    localparam logic [AW:0]    LAST_IDX = (AW+1)'(NREG - 1);
    localparam logic [AW-1:0]  SP_A     = AW'(SP_IDX);
    localparam logic [AW-1:0]  GP_A     = AW'(GP_IDX);
    localparam logic [AW-1:0]  DBG_A    = AW'(DBG_IDX);
    localparam logic [BW-1:0]  INT_B    = BW'(BANK_INT);

    // Flat bus fields viewed as per-port arrays (same bit layout).
    logic [NRD-1:0][AW-1:0]   raddr;
    logic [NRD-1:0][BW-1:0]   rbank;
    logic [NRD-1:0][XLEN-1:0] rdata;
    logic [NWR-1:0][AW-1:0]   waddr;
    logic [NWR-1:0][BW-1:0]   wbank;
    logic [NWR-1:0][XLEN-1:0] wdata;

    assign raddr       = bus.rd_addr;
    assign rbank       = bus.rd_bank;
    assign waddr       = bus.wr_addr;
    assign wbank       = bus.wr_bank;
    assign wdata       = bus.wr_data;
    assign bus.rd_data = rdata;

    // ---------------------------------------------------------------- init FSM
    rf_state_e   state, state_nxt;
    logic [AW:0] clr_idx, clr_nxt;   // one spare bit so NREG-1 -> NREG never wraps
    logic        init_done, done_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= INIT;
            clr_idx   <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            clr_idx   <= clr_nxt;
            init_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        clr_nxt   = clr_idx;
        done_nxt  = init_done;
        case (state)
            INIT: begin
                clr_nxt = clr_idx + 1'b1;
                if (clr_idx == LAST_IDX) begin
                    state_nxt = READY;
                    done_nxt  = 1'b1;
                end
            end
            READY: ;
            default: state_nxt = INIT;
        endcase
    end

    assign bus.init_done = init_done;

    // ------------------------------------------------------- write qualification
    // A write is live only in READY, to an existing bank, and not to integer x0.
    // The same qualifier drives both the bank write enables and the bypass.
    logic [NWR-1:0] wr_live;

    always_comb begin
        for (int w = 0; w < NWR; w++) begin
            wr_live[w] = (state == READY) && bus.wr_en[w]
                      && (int'(wbank[w]) < NBANKS)
                      && !((wbank[w] == INT_B) && (waddr[w] == '0));
        end
    end

    // ------------------------------------------------------- bank write steering
    logic [NBANKS-1:0][NWR-1:0]           bk_we;
    logic [NBANKS-1:0][NWR-1:0][AW-1:0]   bk_waddr;
    logic [NBANKS-1:0][NWR-1:0][XLEN-1:0] bk_wdata;

    always_comb begin
        for (int b = 0; b < NBANKS; b++) begin
            for (int w = 0; w < NWR; w++) begin
                bk_we[b][w]    = wr_live[w] && (wbank[w] == BW'(b));
                bk_waddr[b][w] = waddr[w];
                bk_wdata[b][w] = wdata[w];
            end
            // During INIT, port 0 of every bank is taken over by the clear engine
            // (wr_live is already low, so user writes are dropped).
            if (state == INIT) begin
                bk_we[b][0]    = 1'b1;
                bk_waddr[b][0] = clr_idx[AW-1:0];
                bk_wdata[b][0] = '0;
                if (b == BANK_INT && clr_idx[AW-1:0] == SP_A) bk_wdata[b][0] = XLEN'(SP_INIT);
                if (b == BANK_INT && clr_idx[AW-1:0] == GP_A) bk_wdata[b][0] = XLEN'(GP_INIT);
            end
        end
    end

    // ------------------------------------------------------------------- banks
    logic [NBANKS-1:0][NRD-1:0][XLEN-1:0] bk_rdata;
    logic [XLEN-1:0]                      dbg_val;

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        if (b == BANK_INT) begin : g_int
            // Integer bank carries one extra read port tapping register a0.
            logic [NRD:0][XLEN-1:0] rd_all;
            regfile_bank #(
                .XLEN(XLEN), .NREG(NREG), .NRD(NRD + 1), .NWR(NWR), .ZERO_R0(1'b1)
            ) u_bank (
                .clk   (clk),
                .we    (bk_we[b]),
                .waddr (bk_waddr[b]),
                .wdata (bk_wdata[b]),
                .raddr ({DBG_A, raddr}),
                .rdata (rd_all)
            );
            assign bk_rdata[b] = rd_all[NRD-1:0];
            assign dbg_val     = rd_all[NRD];
        end else begin : g_fp
            regfile_bank #(
                .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .ZERO_R0(1'b0)
            ) u_bank (
                .clk   (clk),
                .we    (bk_we[b]),
                .waddr (bk_waddr[b]),
                .wdata (bk_wdata[b]),
                .raddr (raddr),
                .rdata (bk_rdata[b])
            );
        end
    end

    // -------------------------------------------------------------- read muxing
    always_comb begin
        for (int r = 0; r < NRD; r++) begin
            rdata[r] = '0;                      // out-of-range bank reads 0
            for (int b = 0; b < NBANKS; b++) begin
                if (rbank[r] == BW'(b)) rdata[r] = bk_rdata[b][r];
            end
            // Ascending port order gives the same highest-port-wins rule as the banks.
            if (BYPASS != 0) begin
                for (int w = 0; w < NWR; w++) begin
                    if (wr_live[w] && (wbank[w] == rbank[r]) && (waddr[w] == raddr[r])) begin
                        rdata[r] = wdata[w];
                    end
                end
            end
            if (state != READY) rdata[r] = '0;
        end
    end

    assign bus.dbg_a0 = (state == READY) ? dbg_val : '0;

endmodule

// File: tb/tb_regfile_banked.sv
module tb_regfile_banked;
    import core_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_banked_if #(.XLEN(32), .AW(5), .BW(1), .NRD(3), .NWR(2)) if_a ();
    regfile_banked_if #(.XLEN(32), .AW(5), .BW(1), .NRD(3), .NWR(2)) if_b ();
    regfile_banked_if #(.XLEN(32), .AW(4), .BW(1), .NRD(2), .NWR(2)) if_c ();

    regfile_banked #(.BYPASS(1)) u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    regfile_banked #(.BYPASS(0)) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    regfile_banked #(.NREG(16), .NBANKS(1), .NRD(2)) u_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic push(input string t, input logic [31:0] e);
        sb.push_back('{tag: t, exp: e});
    endtask

    task automatic check(input logic [31:0] obs);
        sb_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL sb_empty: observed %h with nothing expected", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
        end
    endtask

    // Drive the same read/write on both 32-entry instances (bypass on/off).
    task automatic set_rd(input int p, input int bank, input int addr);
        if_a.rd_addr[p*5 +: 5] = 5'(addr);
        if_a.rd_bank[p]        = 1'(bank);
        if_b.rd_addr[p*5 +: 5] = 5'(addr);
        if_b.rd_bank[p]        = 1'(bank);
    endtask

    task automatic set_wr(input int p, input bit en, input int bank, input int addr,
                          input logic [31:0] d);
        if_a.wr_en[p]           = en;
        if_a.wr_addr[p*5 +: 5]  = 5'(addr);
        if_a.wr_bank[p]         = 1'(bank);
        if_a.wr_data[p*32 +: 32] = d;
        if_b.wr_en[p]           = en;
        if_b.wr_addr[p*5 +: 5]  = 5'(addr);
        if_b.wr_bank[p]         = 1'(bank);
        if_b.wr_data[p*32 +: 32] = d;
    endtask

    task automatic clr_wr();
        if_a.wr_en = '0;
        if_b.wr_en = '0;
        if_c.wr_en = '0;
    endtask

    task automatic set_rd_c(input int p, input int addr);
        if_c.rd_addr[p*4 +: 4] = 4'(addr);
        if_c.rd_bank[p]        = 1'b0;
    endtask

    task automatic set_wr_c(input int p, input int addr, input logic [31:0] d);
        if_c.wr_en[p]            = 1'b1;
        if_c.wr_addr[p*4 +: 4]   = 4'(addr);
        if_c.wr_bank[p]          = 1'b0;
        if_c.wr_data[p*32 +: 32] = d;
    endtask

    function automatic logic [31:0] rd_a(input int p);
        return if_a.rd_data[p*32 +: 32];
    endfunction
    function automatic logic [31:0] rd_b(input int p);
        return if_b.rd_data[p*32 +: 32];
    endfunction
    function automatic logic [31:0] rd_c(input int p);
        return if_c.rd_data[p*32 +: 32];
    endfunction

    initial begin
        if_a.rd_addr = '0; if_a.rd_bank = '0; if_a.wr_addr = '0; if_a.wr_bank = '0; if_a.wr_data = '0;
        if_b.rd_addr = '0; if_b.rd_bank = '0; if_b.wr_addr = '0; if_b.wr_bank = '0; if_b.wr_data = '0;
        if_c.rd_addr = '0; if_c.rd_bank = '0; if_c.wr_addr = '0; if_c.wr_bank = '0; if_c.wr_data = '0;
        clr_wr();

        // Reset held for three cycles.
        repeat (3) @(negedge clk);
        push("rst_init_done", 32'd0); check({31'b0, if_a.init_done});
        push("rst_dbg_a0",    32'd0); check(if_a.dbg_a0);
        rst = 1'b1;

        // Init sequence: count edges; a write pulsed mid-init must be dropped.
        for (int e = 1; e <= 32; e++) begin
            @(posedge clk); #1;
            push($sformatf("init_done_a_e%0d", e), {31'b0, e >= 32});
            check({31'b0, if_a.init_done});
            push($sformatf("init_done_c_e%0d", e), {31'b0, e >= 16});
            check({31'b0, if_c.init_done});
            if (e == 5) begin
                set_wr(0, 1'b1, BANK_INT, 5, 32'hDEADBEEF);
                set_rd(0, BANK_INT, 2);
                set_rd(1, BANK_INT, 5);
                #1;
                push("init_rd_zero",    32'd0); check(rd_a(0));
                push("init_no_bypass",  32'd0); check(rd_a(1));
                push("init_dbg_zero",   32'd0); check(if_a.dbg_a0);
            end
            if (e == 6) clr_wr();
        end
        push("init_done_b", 32'd1); check({31'b0, if_b.init_done});

        // Post-init contents.
        set_rd(0, BANK_INT, 2);
        set_rd(1, BANK_INT, 3);
        set_rd(2, BANK_FP, 7);
        #1;
        push("sp_init", 32'd524284); check(rd_a(0));
        push("gp_init", 32'd262140); check(rd_a(1));
        push("fp7_clr", 32'd0);      check(rd_a(2));
        set_rd(0, BANK_INT, 5);
        #1;
        push("int5_dropped", 32'd0); check(rd_a(0));
        push("dbg_a0_clr",   32'd0); check(if_a.dbg_a0);

        // Two ports write int[9] in the same cycle: port 1 wins.
        set_wr(0, 1'b1, BANK_INT, 9, 32'h11);
        set_wr(1, 1'b1, BANK_INT, 9, 32'h22);
        set_rd(0, BANK_INT, 9);
        #1;
        push("prio_bypass_a", 32'h22); check(rd_a(0));
        push("prio_nobyp_b",  32'h0);  check(rd_b(0));
        @(posedge clk); #1;
        clr_wr();
        #1;
        push("prio_a", 32'h22); check(rd_a(0));
        push("prio_b", 32'h22); check(rd_b(0));

        // Writes to x0 are discarded and never bypassed.
        set_wr(0, 1'b1, BANK_INT, 0, 32'hFFFFFFFF);
        set_rd(0, BANK_INT, 0);
        #1;
        push("x0_bypass", 32'd0); check(rd_a(0));
        @(posedge clk); #1;
        clr_wr();
        #1;
        push("x0_a", 32'd0); check(rd_a(0));
        push("x0_b", 32'd0); check(rd_b(0));

        // Bypass and bank separation.
        set_wr(0, 1'b1, BANK_FP, 4, 32'h3F800000);
        set_rd(0, BANK_FP, 4);
        set_rd(1, BANK_INT, 4);
        #1;
        push("byp_fp_a",   32'h3F800000); check(rd_a(0));
        push("byp_int_a",  32'd0);        check(rd_a(1));
        push("nobyp_fp_b", 32'd0);        check(rd_b(0));
        push("nobyp_int_b",32'd0);        check(rd_b(1));
        @(posedge clk); #1;
        clr_wr();
        #1;
        push("fp4_b_next", 32'h3F800000); check(rd_b(0));
        push("fp4_a_next", 32'h3F800000); check(rd_a(0));
        push("int4_a",     32'd0);        check(rd_a(1));

        // Mid-operation asynchronous reset.
        set_wr(0, 1'b1, BANK_INT, 10, 32'h1234);
        @(posedge clk); #1;
        clr_wr();
        #1;
        push("dbg_a0_a", 32'h1234); check(if_a.dbg_a0);
        push("dbg_a0_b", 32'h1234); check(if_b.dbg_a0);
        #3;
        rst = 1'b0;
        #1;
        push("mid_rst_done", 32'd0); check({31'b0, if_a.init_done});
        push("mid_rst_dbg",  32'd0); check(if_a.dbg_a0);
        @(negedge clk);
        rst = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            @(posedge clk); #1;
            if (e == 31 || e == 32) begin
                push($sformatf("reinit_a_e%0d", e), {31'b0, e == 32});
                check({31'b0, if_a.init_done});
            end
            if (e == 15 || e == 16) begin
                push($sformatf("reinit_c_e%0d", e), {31'b0, e == 16});
                check({31'b0, if_c.init_done});
            end
        end
        set_rd(0, BANK_INT, 10);
        #1;
        push("reinit_int10", 32'd0); check(rd_a(0));
        push("reinit_dbg",   32'd0); check(if_a.dbg_a0);

        // Small instance: 16 registers, one bank, two read ports.
        set_wr_c(0, 0, 32'hFFFFFFFF);
        set_wr_c(1, 15, 32'hCAFE0015);
        @(posedge clk); #1;
        clr_wr();
        set_rd_c(0, 15);
        set_rd_c(1, 0);
        #1;
        push("c_int15", 32'hCAFE0015); check(rd_c(0));
        push("c_int0",  32'd0);        check(rd_c(1));

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_leftover: observed %0d pending expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
